// File: rtl/fp_pkg.sv
// Shared types and helpers for the floating-point add/sub sequencer.
package fp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } state_t;

    localparam int unsigned FLG_INVALID   = 3;
    localparam int unsigned FLG_OVERFLOW  = 2;
    localparam int unsigned FLG_UNDERFLOW = 1;
    localparam int unsigned FLG_INEXACT   = 0;

    // Patterns are built in a 64-bit container; callers truncate to their width.
    function automatic logic [63:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
        logic [63:0] ones;
        ones = (64'd1 << exp_w) - 64'd1;
        return (ones << man_w) | (64'd1 << (man_w - 1));
    endfunction

    function automatic logic [63:0] fp_inf(input logic sign, input int unsigned exp_w,
                                           input int unsigned man_w);
        logic [63:0] ones;
        ones = (64'd1 << exp_w) - 64'd1;
        return (ones << man_w) | ({63'd0, sign} << (exp_w + man_w));
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a {hidden, frac, G, R, S} mantissa with
// renormalise-on-carry and overflow-to-infinity.
module fp_round_rne #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                     sign,
    input  logic [EXP_W-1:0]         exp_in,
    input  logic [MAN_W+3:0]         mant,
    output logic [EXP_W+MAN_W:0]     res_c,
    output logic                     overflow_c,
    output logic                     inexact_c
);

    localparam int unsigned EMAX = (1 << EXP_W) - 1;
    localparam int unsigned MW2  = MAN_W + 2;
    localparam int unsigned EW1  = EXP_W + 1;

    logic             lsb, g, r, s, inc;
    logic [MAN_W+1:0] m_inc;
    logic [EXP_W:0]   e_adj;
    logic [MAN_W-1:0] frac;

    always_comb begin
        lsb        = mant[3];
        g          = mant[2];
        r          = mant[1];
        s          = mant[0];
        inc        = g & (r | s | lsb);
        m_inc      = {1'b0, mant[MAN_W+3:3]} + MW2'(inc);
        // A carry out of the increment leaves 10.00..0: shift right, bump exponent.
        e_adj      = {1'b0, exp_in} + EW1'(m_inc[MAN_W+1]);
        frac       = m_inc[MAN_W+1] ? m_inc[MAN_W:1] : m_inc[MAN_W-1:0];
        overflow_c = (32'(e_adj) >= EMAX);
        inexact_c  = g | r | s | overflow_c;
        if (overflow_c) begin
            res_c = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            res_c = {sign, e_adj[EXP_W-1:0], frac};
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor with valid/ready handshakes,
// RNE rounding, special-value handling and exception flags.
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     op,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [3:0]               flags
);

    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int unsigned DW    = MAN_W + 4;
    localparam int unsigned SW    = DW + 1;
    localparam int unsigned SHMAX = MAN_W + 3;

    state_t state, next_state;

    logic [W-1:0]     a_q, b_q;
    logic             op_q;
    logic             sa_q, sb_q;
    logic [EXP_W-1:0] ea_q, eb_q;
    logic [MAN_W:0]   ma_q, mb_q;
    logic             spec_q, spec_inv_q;
    logic [W-1:0]     spec_res_q;
    logic             sign_q, eff_sub_q;
    logic [EXP_W-1:0] exp_q;
    logic [DW-1:0]    mx_q, my_q;
    logic [SW-1:0]    mant_q;

    // Unpack and special-value classification
    logic [EXP_W-1:0] ea_c, eb_c;
    logic [MAN_W-1:0] fa_c, fb_c;
    logic             sbe_c, nan_a_c, nan_b_c, inf_a_c, inf_b_c;
    logic             spec_c, spec_inv_c;
    logic [W-1:0]     spec_res_c;

    always_comb begin
        ea_c       = a_q[W-2:MAN_W];
        eb_c       = b_q[W-2:MAN_W];
        fa_c       = a_q[MAN_W-1:0];
        fb_c       = b_q[MAN_W-1:0];
        sbe_c      = b_q[W-1] ^ op_q;
        nan_a_c    = (ea_c == {EXP_W{1'b1}}) && (fa_c != '0);
        nan_b_c    = (eb_c == {EXP_W{1'b1}}) && (fb_c != '0);
        inf_a_c    = (ea_c == {EXP_W{1'b1}}) && (fa_c == '0);
        inf_b_c    = (eb_c == {EXP_W{1'b1}}) && (fb_c == '0);
        spec_c     = 1'b1;
        spec_inv_c = 1'b0;
        spec_res_c = W'(fp_qnan(EXP_W, MAN_W));
        if (nan_a_c || nan_b_c) begin
            spec_inv_c = 1'b0;
        end else if (inf_a_c && inf_b_c && (a_q[W-1] != sbe_c)) begin
            spec_inv_c = 1'b1;
        end else if (inf_a_c) begin
            spec_res_c = W'(fp_inf(a_q[W-1], EXP_W, MAN_W));
        end else if (inf_b_c) begin
            spec_res_c = W'(fp_inf(sbe_c, EXP_W, MAN_W));
        end else begin
            spec_c = 1'b0;
        end
    end

    // Order by magnitude and align the smaller operand with a sticky bit
    logic             swap_c, sx_c, sy_c;
    logic [EXP_W-1:0] ex_c, ey_c, d_c;
    logic [MAN_W:0]   mxs_c, mys_c;
    logic [DW-1:0]    yext_c, mask_c, yal_c;

    always_comb begin
        swap_c = {eb_q, mb_q} > {ea_q, ma_q};
        sx_c   = swap_c ? sb_q : sa_q;
        sy_c   = swap_c ? sa_q : sb_q;
        ex_c   = swap_c ? eb_q : ea_q;
        ey_c   = swap_c ? ea_q : eb_q;
        mxs_c  = swap_c ? mb_q : ma_q;
        mys_c  = swap_c ? ma_q : mb_q;
        d_c    = ex_c - ey_c;
        yext_c = {mys_c, 3'b000};
        mask_c = '0;
        if (32'(d_c) >= SHMAX) begin
            yal_c = {{(DW-1){1'b0}}, |mys_c};
        end else begin
            mask_c = (DW'(1) << d_c) - DW'(1);
            yal_c  = (yext_c >> d_c) | {{(DW-1){1'b0}}, |(yext_c & mask_c)};
        end
    end

    logic [SW-1:0] sum_c;
    logic          carry_c, hid_c, mzero_c, exp_low_c, flush_c, norm_done_c;

    always_comb begin
        sum_c       = eff_sub_q ? ({1'b0, mx_q} - {1'b0, my_q})
                                : ({1'b0, mx_q} + {1'b0, my_q});
        carry_c     = mant_q[SW-1];
        hid_c       = mant_q[DW-1];
        mzero_c     = (mant_q == '0);
        exp_low_c   = (exp_q <= EXP_W'(1));
        flush_c     = !carry_c && !mzero_c && !hid_c && exp_low_c;
        norm_done_c = carry_c || mzero_c || hid_c || exp_low_c;
    end

    logic [W-1:0] rnd_res_c;
    logic         rnd_ovf_c, rnd_inx_c;

    fp_round_rne #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .sign       (sign_q),
        .exp_in     (exp_q),
        .mant       (mant_q[DW-1:0]),
        .res_c      (rnd_res_c),
        .overflow_c (rnd_ovf_c),
        .inexact_c  (rnd_inx_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state == ST_IDLE);
            out_valid <= (next_state == ST_DONE);
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:   if (in_valid && in_ready) next_state = ST_UNPACK;
            ST_UNPACK: next_state = ST_ALIGN;
            ST_ALIGN:  next_state = spec_q ? ST_DONE : ST_ADD;
            ST_ADD:    next_state = ST_NORM;
            ST_NORM:   if (norm_done_c) next_state = ST_ROUND;
            ST_ROUND:  next_state = ST_DONE;
            ST_DONE:   if (out_ready) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Datapath registers; only meaningful while an operation is in flight
    always_ff @(posedge clk) begin
        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    a_q  <= a;
                    b_q  <= b;
                    op_q <= op;
                end
            end
            ST_UNPACK: begin
                sa_q       <= a_q[W-1];
                sb_q       <= sbe_c;
                ea_q       <= ea_c;
                eb_q       <= eb_c;
                ma_q       <= (ea_c != '0) ? {1'b1, fa_c} : '0;
                mb_q       <= (eb_c != '0) ? {1'b1, fb_c} : '0;
                spec_q     <= spec_c;
                spec_inv_q <= spec_inv_c;
                spec_res_q <= spec_res_c;
            end
            ST_ALIGN: begin
                sign_q    <= sx_c;
                eff_sub_q <= sx_c ^ sy_c;
                exp_q     <= ex_c;
                mx_q      <= {mxs_c, 3'b000};
                my_q      <= yal_c;
            end
            ST_ADD: begin
                mant_q <= sum_c;
                if (eff_sub_q && (sum_c == '0)) sign_q <= 1'b0;
            end
            ST_NORM: begin
                if (carry_c) begin
                    mant_q <= {1'b0, mant_q[SW-1:2], mant_q[1] | mant_q[0]};
                    exp_q  <= exp_q + EXP_W'(1);
                end else if (mzero_c) begin
                    exp_q <= '0;
                end else if (flush_c) begin
                    mant_q <= '0;
                    exp_q  <= '0;
                end else if (!hid_c) begin
                    mant_q <= mant_q << 1;
                    exp_q  <= exp_q - EXP_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Result and flags are held stable outside the producing states
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            flags  <= '0;
        end else begin
            if ((state == ST_IDLE) && in_valid && in_ready) flags <= '0;
            if ((state == ST_ALIGN) && spec_q) begin
                result             <= spec_res_q;
                flags[FLG_INVALID] <= spec_inv_q;
            end
            if ((state == ST_NORM) && flush_c) begin
                flags[FLG_UNDERFLOW] <= 1'b1;
                flags[FLG_INEXACT]   <= 1'b1;
            end
            if (state == ST_ROUND) begin
                result              <= rnd_res_c;
                flags[FLG_OVERFLOW] <= rnd_ovf_c;
                flags[FLG_INEXACT]  <= flags[FLG_INEXACT] | rnd_inx_c;
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed scoreboard bench for fp_addsub_seq (single precision).
module tb_fp_addsub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic top, input logic [31:0] eres, input logic [3:0] eflg,
                          input int elat, input int hold);
        exp_t e;
        exp_t got;
        int   n;
        e.res = eres;
        e.flg = eflg;
        e.lat = elat;
        sb_q.push_back(e);
        @(negedge clk);
        check({tag, "_ready_before"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        op       = top;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_ready_busy"}, 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_timeout"}, 64'(out_valid), 64'd1);
        got = sb_q.pop_front();
        check({tag, "_result"}, 64'(result), 64'(got.res));
        check({tag, "_flags"}, 64'(flags), 64'(got.flg));
        check({tag, "_latency"}, 64'(n), 64'(got.lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_result"}, 64'(result), 64'(got.res));
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_valid_after"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_flags", 64'(flags), 64'd0);
        rst = 1'b0;

        run_op("add_1p2",    32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 4'b0000, 5, 4);
        run_op("sub_1m1",    32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 4'b0000, 5, 0);
        run_op("sub_1p5m1",  32'h3FC0_0000, 32'h3F80_0000, 1'b1, 32'h3F00_0000, 4'b0000, 6, 0);
        run_op("tie_even",   32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 4'b0001, 5, 0);
        run_op("overflow",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 4'b0101, 5, 0);
        run_op("inf_m_inf",  32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 4'b1000, 2, 0);
        run_op("nan_in",     32'h7F80_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 4'b0000, 2, 0);
        run_op("ninf_m_1",   32'hFF80_0000, 32'h3F80_0000, 1'b1, 32'hFF80_0000, 4'b0000, 2, 0);
        run_op("sub_2m3",    32'h4000_0000, 32'h4040_0000, 1'b1, 32'hBF80_0000, 4'b0000, 6, 0);
        run_op("long_norm",  32'h3F80_0000, 32'h3F7F_FFFF, 1'b1, 32'h3380_0000, 4'b0000, 29, 0);
        run_op("underflow",  32'h0080_0000, 32'h0080_0001, 1'b1, 32'h8000_0000, 4'b0011, 5, 0);
        run_op("negz_negz",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 4'b0000, 5, 0);

        // Reset while the long normalisation is in progress
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h3F80_0000;
        b        = 32'h3F7F_FFFF;
        op       = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_result", 64'(result), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_output", 64'(seen), 64'd0);

        run_op("after_rst",  32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 4'b0000, 5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
- Parametrised multi-cycle IEEE-754-style floating-point adder/subtractor. Next generation of the 32-bit addition stage.
- Generalises exponent and mantissa width.
- Adds over the 32-bit stage: valid/ready handshakes, round-to-nearest-even, special-value handling and exception flags.
- Sits between the calculator operand registers and the result/display path; one operation in flight at a time.

Parameters:
- EXP_W, 8, exponent field width (>=3).
- MAN_W, 23, stored fraction width, hidden bit excluded (>=4).
- Derived localparams: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1; EMAX = 2^EXP_W-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/op present
- in_ready  out  1  block can accept an operation (high only in IDLE)
- op  in  1  0 = A+B, 1 = A-B
- a  in  W  operand A {sign, exp, frac}
- b  in  W  operand B
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- result  out  W  packed result
- flags  out  4  {invalid, overflow, underflow, inexact}, valid with out_valid

Behaviour:
- Reset: state = IDLE; in_ready = 1, out_valid = 0, result = 0, flags = 0 from the first cycle after rst sampled high.
- Reset mid-operation aborts the operation with no output. Reset has priority over all other events.
- Handshake:
  - Accept when in_valid && in_ready; a, b, op are registered on that edge.
  - Output transfers when out_valid && out_ready.
  - result/flags stay stable while out_valid=1 and out_ready=0.
- States: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
- UNPACK (1 cycle):
  - Split the fields; the hidden bit is 1 when exp != 0.
  - exp == 0 is treated as zero: denormals flushed to zero, sign kept.
  - Effective sign of B = b.sign ^ op.
  - Special cases jump directly to DONE:
    - any NaN -> quiet NaN {0, all-ones, 1 followed by zeros}.
    - +inf + -inf (effective) -> quiet NaN, invalid = 1.
    - one inf -> that inf.
- ALIGN (1 cycle):
  - Swap so |X| >= |Y| (compare exp, then mantissa).
  - d = eX - eY. Shift the Y mantissa right by d into a MAN_W+4 datapath: hidden, frac, guard, round, sticky.
  - The sticky bit ORs every shifted-out bit. d >= MAN_W+3 gives Y = sticky only.
- ADD (1 cycle):
  - Same effective sign: add. Different: subtract Y from X (never negative).
  - Result sign = sign of X.
  - Exact zero difference -> +0 (round-to-nearest-even).
- NORM, variable length:
  - On carry-out: shift right once (sticky absorbs the lost bit), exp+1; takes 1 cycle.
  - Otherwise: shift left one bit per cycle, exp-1, until hidden=1 or exp reaches 1. At most MAN_W+3 cycles.
  - exp reaching 0 with hidden=0: flush to signed zero; underflow = 1, inexact = 1 if the mantissa was non-zero.
- ROUND (1 cycle):
  - Round-to-nearest-even: increment when G && (R || S || lsb).
  - Mantissa overflow from the increment -> renormalise, exp+1.
  - inexact = G|R|S.
  - exp >= EMAX -> signed inf, overflow = 1, inexact = 1.
- DONE: out_valid = 1; leave to IDLE on out_ready. in_ready stays low until then.
- Latency (accept to out_valid):
  - Special cases: 2 cycles.
  - Normal path: 5 + (left-shift count) cycles; minimum 5.
- flags clear on every new acceptance.

Decomposition:
- Package fp_pkg:
  - State enum.
  - Flag bit indices: FLG_INVALID=3, FLG_OVERFLOW=2, FLG_UNDERFLOW=1, FLG_INEXACT=0.
  - Functions for quiet NaN and inf patterns parametrised by EXP_W/MAN_W.
- One sub-module, fp_round_rne: combinational GRS rounding, renormalise-on-carry and overflow detect; reused later by the multiplier.

Test Plan (EXP_W=8, MAN_W=23):
- a=0x3F800000, b=0x40000000, op=0 (1.0+2.0) -> result 0x40400000, flags 0000, out_valid 5 cycles after accept.
- a=0x3F800000, b=0x3F800000, op=1 (1.0-1.0) -> result 0x00000000, flags 0000.
- a=0x3FC00000, b=0x3F800000, op=1 (1.5-1.0) -> result 0x3F000000 after one NORM left shift (latency 6).
- a=0x3F800000, b=0x33800000, op=0 (tie case) -> result 0x3F800000, inexact=1.
- a=0x7F7FFFFF, b=0x7F7FFFFF, op=0 -> result 0x7F800000, overflow=1, inexact=1.
- a=0x7F800000, b=0x7F800000, op=1 -> result 0x7FC00000, invalid=1, latency 2.
- Hold out_ready=0 for 4 cycles -> result stable and in_ready=0.
- Assert rst in NORM -> out_valid=0, in_ready=1 next cycle, no result emitted.
